// File: rtl/move_cmd_gen.sv
// Turns debounced direction levels into one handshaked move command per deliberate press,
// then locks out until all buttons have been released long enough to re-arm.
module move_cmd_gen #(
    parameter int PRESS_CYCLES   = 250000,
    parameter int RELEASE_CYCLES = 250000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       u,
    input  logic       d,
    input  logic       l,
    input  logic       r,
    output logic       move_valid,
    output logic [1:0] move_dir,
    input  logic       move_ready,
    output logic       armed
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        QUALIFY      = 2'd1,
        ISSUE        = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       dir_q, dir_nx;
    logic             any_btn;
    logic             cap_btn;

    // Fixed priority u > d > l > r; encoding matches move_dir.
    function automatic logic [1:0] prio_dir(input logic bu, input logic bd,
                                            input logic bl, input logic br);
        logic [1:0] res;
        res = 2'b11;
        if (bu)      res = 2'b00;
        else if (bd) res = 2'b01;
        else if (bl) res = 2'b10;
        else if (br) res = 2'b11;
        return res;
    endfunction

    function automatic logic sel_btn(input logic [1:0] dir, input logic bu, input logic bd,
                                     input logic bl, input logic br);
        logic res;
        case (dir)
            2'b00:   res = bu;
            2'b01:   res = bd;
            2'b10:   res = bl;
            default: res = br;
        endcase
        return res;
    endfunction

    assign any_btn = u | d | l | r;
    assign cap_btn = sel_btn(dir_q, u, d, l, r);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dir_nx   = dir_q;
        case (state)
            IDLE: begin
                if (any_btn) begin
                    dir_nx   = prio_dir(u, d, l, r);
                    cnt_nx   = '0;
                    state_nx = QUALIFY;
                end
            end
            QUALIFY: begin
                if (!cap_btn) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (cnt == PRESS_LAST) begin
                    state_nx = ISSUE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ISSUE: begin
                // move_valid is implied by this state, so ready alone completes the handshake.
                if (move_ready) begin
                    cnt_nx   = '0;
                    state_nx = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (any_btn) begin
                    cnt_nx = '0;
                end else if (cnt == RELEASE_LAST) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = WAIT_RELEASE;
            end
        endcase
    end

    // Reset lands in WAIT_RELEASE so a button held through reset must be released first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_RELEASE;
            cnt   <= '0;
            dir_q <= 2'b00;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            dir_q <= dir_nx;
        end
    end

    assign move_valid = (state == ISSUE);
    assign move_dir   = dir_q;
    assign armed      = (state == IDLE);

endmodule

// File: tb/tb_move_cmd_gen.sv
// Directed bench for move_cmd_gen with PRESS_CYCLES=4, RELEASE_CYCLES=3.
module tb_move_cmd_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       u = 1'b0, d = 1'b0, l = 1'b0, r = 1'b0;
    logic       move_ready = 1'b0;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       armed;

    int total  = 0;
    int passed = 0;
    int vcount = 0;

    move_cmd_gen #(
        .PRESS_CYCLES(4),
        .RELEASE_CYCLES(3),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .u(u),
        .d(d),
        .l(l),
        .r(r),
        .move_valid(move_valid),
        .move_dir(move_dir),
        .move_ready(move_ready),
        .armed(armed)
    );

    always #5 clk = ~clk;

    // Advance one edge, observe 1 time unit later, and tally cycles with a pending command.
    task automatic tick;
        @(posedge clk);
        #1;
        if (move_valid === 1'b1) vcount++;
    endtask

    task automatic test_reset;
        rst = 1'b1; u = 0; d = 0; l = 0; r = 0; move_ready = 1'b0;
        tick; tick;
        total++; if (move_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", move_valid); else passed++;
        total++; if (move_dir !== 2'b00) $display("FAIL rst_dir: got %b want 00", move_dir); else passed++;
        total++; if (armed !== 1'b0) $display("FAIL rst_armed: got %b want 0", armed); else passed++;
        rst = 1'b0;
        tick; tick;
        total++; if (armed !== 1'b0) $display("FAIL arm_early: got %b want 0", armed); else passed++;
        tick;
        total++; if (armed !== 1'b1) $display("FAIL arm_after_reset: got %b want 1", armed); else passed++;
    endtask

    task automatic test_single_press;
        int v0;
        v0 = vcount;
        u = 1'b1; move_ready = 1'b1;
        repeat (4) tick;
        total++; if (move_valid !== 1'b0) $display("FAIL press_early: got %b want 0", move_valid); else passed++;
        tick;
        total++; if (move_valid !== 1'b1) $display("FAIL press_valid: got %b want 1", move_valid); else passed++;
        total++; if (move_dir !== 2'b00) $display("FAIL press_dir: got %b want 00", move_dir); else passed++;
        u = 1'b0;
        tick;
        total++; if (move_valid !== 1'b0) $display("FAIL press_drop: got %b want 0", move_valid); else passed++;
        total++; if (vcount - v0 !== 1) $display("FAIL press_once: got %0d want 1", vcount - v0); else passed++;
        repeat (3) tick;
        total++; if (armed !== 1'b1) $display("FAIL press_rearm: got %b want 1", armed); else passed++;
    endtask

    task automatic test_short_pulse;
        int v0;
        v0 = vcount;
        l = 1'b1;
        tick;
        total++; if (armed !== 1'b0) $display("FAIL pulse_qualify: got %b want 0", armed); else passed++;
        tick; tick;
        l = 1'b0;
        tick;
        total++; if (armed !== 1'b1) $display("FAIL pulse_idle: got %b want 1", armed); else passed++;
        total++; if (vcount !== v0) $display("FAIL pulse_nocmd: got %0d want %0d", vcount, v0); else passed++;
    endtask

    task automatic test_priority;
        int v0;
        v0 = vcount;
        u = 1'b1; r = 1'b1;
        repeat (5) tick;
        total++; if (move_valid !== 1'b1) $display("FAIL prio_valid: got %b want 1", move_valid); else passed++;
        total++; if (move_dir !== 2'b00) $display("FAIL prio_dir: got %b want 00", move_dir); else passed++;
        repeat (5) tick;
        total++; if (vcount - v0 !== 1) $display("FAIL prio_once: got %0d want 1", vcount - v0); else passed++;
        u = 1'b0; r = 1'b0;
        repeat (3) tick;
        total++; if (armed !== 1'b1) $display("FAIL prio_rearm: got %b want 1", armed); else passed++;
    endtask

    task automatic test_backpressure;
        int v0;
        int bad;
        v0 = vcount; bad = 0;
        move_ready = 1'b0; r = 1'b1;
        repeat (5) tick;
        total++; if (move_dir !== 2'b11 || move_valid !== 1'b1)
            $display("FAIL bp_first: got valid=%b dir=%b want valid=1 dir=11", move_valid, move_dir); else passed++;
        repeat (10) begin
            tick;
            if (move_valid !== 1'b1 || move_dir !== 2'b11) bad++;
        end
        total++; if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); else passed++;
        move_ready = 1'b1;
        tick;
        total++; if (move_valid !== 1'b0) $display("FAIL bp_accept: got %b want 0", move_valid); else passed++;
        repeat (10) tick;
        total++; if (vcount - v0 !== 11) $display("FAIL bp_cycles: got %0d want 11", vcount - v0); else passed++;
        total++; if (armed !== 1'b0) $display("FAIL bp_locked: got %b want 0", armed); else passed++;
        r = 1'b0;
        repeat (3) tick;
        total++; if (armed !== 1'b1) $display("FAIL bp_rearm: got %b want 1", armed); else passed++;
    endtask

    task automatic test_release_window;
        int v0;
        v0 = vcount;
        move_ready = 1'b1; d = 1'b1;
        repeat (5) tick;
        total++; if (move_dir !== 2'b01 || move_valid !== 1'b1)
            $display("FAIL rel_cmd: got valid=%b dir=%b want valid=1 dir=01", move_valid, move_dir); else passed++;
        d = 1'b0;
        tick; tick; tick;
        d = 1'b1;
        tick;
        d = 1'b0;
        tick; tick;
        total++; if (armed !== 1'b0) $display("FAIL rel_early: got %b want 0", armed); else passed++;
        tick;
        total++; if (armed !== 1'b1) $display("FAIL rel_rearm: got %b want 1", armed); else passed++;
        total++; if (vcount - v0 !== 1) $display("FAIL rel_once: got %0d want 1", vcount - v0); else passed++;
    endtask

    task automatic test_reset_cases;
        int v0;
        v0 = vcount;
        u = 1'b1;
        tick;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        repeat (10) tick;
        total++; if (vcount !== v0) $display("FAIL held_rst_nocmd: got %0d want %0d", vcount, v0); else passed++;
        total++; if (armed !== 1'b0) $display("FAIL held_rst_locked: got %b want 0", armed); else passed++;
        u = 1'b0;
        tick; tick;
        total++; if (armed !== 1'b0) $display("FAIL held_rst_early: got %b want 0", armed); else passed++;
        tick;
        total++; if (armed !== 1'b1) $display("FAIL held_rst_rearm: got %b want 1", armed); else passed++;
        u = 1'b1;
        repeat (5) tick;
        total++; if (move_valid !== 1'b1) $display("FAIL held_rst_cmd: got %b want 1", move_valid); else passed++;
        u = 1'b0;
        repeat (4) tick;
        // Reset while a command is pending.
        v0 = vcount;
        move_ready = 1'b0; l = 1'b1;
        repeat (5) tick;
        total++; if (move_dir !== 2'b10 || move_valid !== 1'b1)
            $display("FAIL issue_cmd: got valid=%b dir=%b want valid=1 dir=10", move_valid, move_dir); else passed++;
        rst = 1'b1;
        tick;
        total++; if (move_valid !== 1'b0) $display("FAIL issue_rst_drop: got %b want 0", move_valid); else passed++;
        rst = 1'b0; l = 1'b0;
        tick; tick;
        total++; if (armed !== 1'b0) $display("FAIL issue_rst_locked: got %b want 0", armed); else passed++;
        tick;
        total++; if (armed !== 1'b1) $display("FAIL issue_rst_rearm: got %b want 1", armed); else passed++;
        total++; if (vcount - v0 !== 1) $display("FAIL issue_rst_count: got %0d want 1", vcount - v0); else passed++;
    endtask

    initial begin
        test_reset;
        test_single_press;
        test_short_pulse;
        test_priority;
        test_backpressure;
        test_release_window;
        test_reset_cases;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
